// File: rtl/fat32_pkg.sv
// Shared constants and types for the FAT32 boot-sector (BPB) reader.
// Holds BPB byte offsets, boot signature bytes and the reader state enum.
package fat32_pkg;

    localparam int unsigned OFF_BYTES_PER_SEC = 11;
    localparam int unsigned OFF_SEC_PER_CLUS  = 13;
    localparam int unsigned OFF_RSVD          = 14;
    localparam int unsigned OFF_NUM_FATS      = 16;
    localparam int unsigned OFF_FATSZ32       = 36;
    localparam int unsigned OFF_ROOT_CLUS     = 44;
    localparam int unsigned OFF_SIG           = 510;

    localparam logic [7:0] SIG_BYTE0 = 8'h55;
    localparam logic [7:0] SIG_BYTE1 = 8'hAA;

    typedef enum logic [2:0] {
        StIdle,
        StRecv,
        StCalc,
        StSum,
        StDone
    } bpb_state_e;

endpackage

// File: rtl/fat32_bpb_reader_if.sv
// Bus between the SD block-read path / file writer and fat32_bpb_reader.
// master: drives start, part_lba, byte_valid, byte_data; observes status and fields.
// slave : the reader; drives busy, done, error and the extracted geometry fields.
interface fat32_bpb_reader_if #(
    parameter int unsigned LBA_W = 32
) ();
    logic             start;
    logic [LBA_W-1:0] part_lba;
    logic             byte_valid;
    logic [7:0]       byte_data;
    logic             busy;
    logic             done;
    logic             error;
    logic [15:0]      reserved_sectors;
    logic [7:0]       num_fats;
    logic [7:0]       sectors_per_cluster;
    logic [31:0]      fat_size;
    logic [31:0]      root_cluster;
    logic [LBA_W-1:0] root_dir_sector;

    modport master (
        output start, part_lba, byte_valid, byte_data,
        input  busy, done, error, reserved_sectors, num_fats, sectors_per_cluster,
               fat_size, root_cluster, root_dir_sector
    );

    modport slave (
        input  start, part_lba, byte_valid, byte_data,
        output busy, done, error, reserved_sectors, num_fats, sectors_per_cluster,
               fat_size, root_cluster, root_dir_sector
    );
endinterface

// File: rtl/fat32_shift_add_mul.sv
// 8-bit x 32-bit sequential multiplier, one shift-add step per cycle, LSB of a first.
// Ports: clk, sys_rst_n (async, active-low), start (loads operands), a, b,
//        done (high during the 8th step; product valid the cycle after), product (40 bits).
module fat32_shift_add_mul (
    input  logic        clk,
    input  logic        sys_rst_n,
    input  logic        start,
    input  logic [7:0]  a,
    input  logic [31:0] b,
    output logic        done,
    output logic [39:0] product
);
    logic [7:0]  a_q;
    logic [39:0] b_q;
    logic [39:0] acc_q;
    logic [2:0]  cnt_q;
    logic        busy_q;

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start) begin
            a_q    <= a;
            b_q    <= {8'd0, b};
            acc_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            if (a_q[0]) begin
                acc_q <= acc_q + b_q;
            end
            a_q   <= a_q >> 1;
            b_q   <= b_q << 1;
            cnt_q <= cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
                busy_q <= 1'b0;
            end
        end
    end

    // Flagged during the last step so the caller can move on without a bubble.
    assign done    = busy_q && (cnt_q == 3'd7);
    assign product = acc_q;
endmodule

// File: rtl/fat32_bpb_reader.sv
// FAT32 boot-sector reader: consumes the 512-byte BPB stream, extracts geometry fields
// and computes root_dir_sector = part_lba + reserved_sectors + num_fats * fat_size.
// Ports: clk, sys_rst_n (async, active-low), bus (fat32_bpb_reader_if.slave).
// Optional: define BPB_SIGNATURE_CHECK_EN to flag a missing 0x55AA signature as error.
module fat32_bpb_reader
    import fat32_pkg::*;
#(
    parameter int unsigned SECTOR_BYTES = 512,
    parameter int unsigned LBA_W        = 32
) (
    input  logic                 clk,
    input  logic                 sys_rst_n,
    fat32_bpb_reader_if.slave    bus
);
    localparam int unsigned CNT_W = $clog2(SECTOR_BYTES);

    bpb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [LBA_W-1:0] part_lba_q;
    logic [LBA_W-1:0] root_q;
    logic [15:0]      bps_q;
    logic [15:0]      rsvd_q;
    logic [7:0]       nfats_q;
    logic [7:0]       spc_q;
    logic [31:0]      fsz_q;
    logic [31:0]      rclus_q;
    logic             error_q;
    logic             byte_acc;
    logic             last_byte;
    logic             mul_start;
    logic             mul_done;
    logic [39:0]      product;
    logic             sig_bad;
    logic             busy;
    logic             done;

    assign byte_acc  = (state_q == StRecv) && bus.byte_valid;
    assign last_byte = (cnt_q == CNT_W'(SECTOR_BYTES - 1));

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (bus.start) state_d = StRecv;
            StRecv: if (byte_acc && last_byte) state_d = StCalc;
            StCalc: if (mul_done) state_d = StSum;
            StSum:  state_d = StDone;
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        mul_start = 1'b0;
        unique case (state_q)
            StRecv: begin
                busy      = 1'b1;
                mul_start = byte_acc && last_byte;
            end
            StCalc, StSum: busy = 1'b1;
            StDone: done = 1'b1;
            default: ;
        endcase
    end

`ifdef BPB_SIGNATURE_CHECK_EN
    logic sig_ok_q;
    assign sig_bad = !sig_ok_q;
`else
    assign sig_bad = 1'b0;
`endif

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_q      <= '0;
            part_lba_q <= '0;
            root_q     <= '0;
            bps_q      <= '0;
            rsvd_q     <= '0;
            nfats_q    <= '0;
            spc_q      <= '0;
            fsz_q      <= '0;
            rclus_q    <= '0;
            error_q    <= 1'b0;
`ifdef BPB_SIGNATURE_CHECK_EN
            sig_ok_q   <= 1'b0;
`endif
        end else begin
            if (state_q == StIdle && bus.start) begin
                cnt_q      <= '0;
                part_lba_q <= bus.part_lba;
`ifdef BPB_SIGNATURE_CHECK_EN
                sig_ok_q   <= 1'b1;
`endif
            end
            if (byte_acc) begin
                // Hold on the final byte so the counter never wraps inside a parse.
                if (!last_byte) begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                case (cnt_q)
                    CNT_W'(OFF_BYTES_PER_SEC):     bps_q[7:0]    <= bus.byte_data;
                    CNT_W'(OFF_BYTES_PER_SEC + 1): bps_q[15:8]   <= bus.byte_data;
                    CNT_W'(OFF_SEC_PER_CLUS):      spc_q         <= bus.byte_data;
                    CNT_W'(OFF_RSVD):              rsvd_q[7:0]   <= bus.byte_data;
                    CNT_W'(OFF_RSVD + 1):          rsvd_q[15:8]  <= bus.byte_data;
                    CNT_W'(OFF_NUM_FATS):          nfats_q       <= bus.byte_data;
                    CNT_W'(OFF_FATSZ32):           fsz_q[7:0]    <= bus.byte_data;
                    CNT_W'(OFF_FATSZ32 + 1):       fsz_q[15:8]   <= bus.byte_data;
                    CNT_W'(OFF_FATSZ32 + 2):       fsz_q[23:16]  <= bus.byte_data;
                    CNT_W'(OFF_FATSZ32 + 3):       fsz_q[31:24]  <= bus.byte_data;
                    CNT_W'(OFF_ROOT_CLUS):         rclus_q[7:0]  <= bus.byte_data;
                    CNT_W'(OFF_ROOT_CLUS + 1):     rclus_q[15:8] <= bus.byte_data;
                    CNT_W'(OFF_ROOT_CLUS + 2):     rclus_q[23:16] <= bus.byte_data;
                    CNT_W'(OFF_ROOT_CLUS + 3):     rclus_q[31:24] <= bus.byte_data;
`ifdef BPB_SIGNATURE_CHECK_EN
                    CNT_W'(OFF_SIG):     if (bus.byte_data != SIG_BYTE0) sig_ok_q <= 1'b0;
                    CNT_W'(OFF_SIG + 1): if (bus.byte_data != SIG_BYTE1) sig_ok_q <= 1'b0;
`endif
                    default: ;
                endcase
            end
            if (state_q == StSum) begin
                root_q  <= LBA_W'(product) + LBA_W'(rsvd_q) + part_lba_q;
                error_q <= (bps_q != 16'(SECTOR_BYTES)) || (nfats_q == 8'd0) || sig_bad;
            end
        end
    end

    fat32_shift_add_mul u_mul (
        .clk       (clk),
        .sys_rst_n (sys_rst_n),
        .start     (mul_start),
        .a         (nfats_q),
        .b         (fsz_q),
        .done      (mul_done),
        .product   (product)
    );

    assign bus.busy                = busy;
    assign bus.done                = done;
    assign bus.error               = error_q;
    assign bus.reserved_sectors    = rsvd_q;
    assign bus.num_fats            = nfats_q;
    assign bus.sectors_per_cluster = spc_q;
    assign bus.fat_size            = fsz_q;
    assign bus.root_cluster        = rclus_q;
    assign bus.root_dir_sector     = root_q;
endmodule

// File: tb/tb_fat32_bpb_reader.sv
// Self-checking bench for fat32_bpb_reader: fixed vector table, hand sequences for
// start-at-done, idle byte_valid and mid-parse reset, then randomized sectors checked
// against an arithmetic reference model.
module tb_fat32_bpb_reader;

    logic clk = 1'b0;
    logic sys_rst_n;

    fat32_bpb_reader_if #(.LBA_W(32)) bif ();

    fat32_bpb_reader #(
        .SECTOR_BYTES (512),
        .LBA_W        (32)
    ) dut (
        .clk       (clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bif)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [7:0] img [512];

    // Model outputs
    logic [31:0] m_root;
    logic        m_err;
    logic [15:0] m_rsvd;
    logic [7:0]  m_nf;
    logic [7:0]  m_spc;
    logic [31:0] m_fsz;
    logic [31:0] m_rclus;

    typedef struct {
        logic [31:0] plba;
        int unsigned rsvd;
        int unsigned nf;
        logic [31:0] fsz;
        int unsigned bps;
        int unsigned spc;
        logic [31:0] rclus;
        logic [7:0]  s1;
        bit          gapped;
        logic [31:0] exp_root;
        logic        exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic build_img(input int unsigned rsvd, input int unsigned nf,
                             input logic [31:0] fsz, input int unsigned bps,
                             input int unsigned spc, input logic [31:0] rclus,
                             input logic [7:0] s0, input logic [7:0] s1);
        for (int i = 0; i < 512; i++) img[i] = 8'($urandom);
        img[11] = 8'(bps);      img[12] = 8'(bps >> 8);
        img[13] = 8'(spc);
        img[14] = 8'(rsvd);     img[15] = 8'(rsvd >> 8);
        img[16] = 8'(nf);
        for (int k = 0; k < 4; k++) begin
            img[36 + k] = 8'(fsz >> (8 * k));
            img[44 + k] = 8'(rclus >> (8 * k));
        end
        img[510] = s0;
        img[511] = s1;
    endtask

    // Reference: read fields back out of the byte image with plain arithmetic.
    task automatic ref_model(input logic [31:0] plba);
        longint unsigned bps, rsvd, nf, fsz, rclus, sum;
        bps = 0; fsz = 0; rclus = 0;
        bps  = longint'(img[11]) + 256 * longint'(img[12]);
        rsvd = longint'(img[14]) + 256 * longint'(img[15]);
        nf   = longint'(img[16]);
        for (int k = 3; k >= 0; k--) begin
            fsz   = fsz * 256 + longint'(img[36 + k]);
            rclus = rclus * 256 + longint'(img[44 + k]);
        end
        sum = (longint'(plba) + rsvd + nf * fsz) % 64'h1_0000_0000;
        m_root  = sum[31:0];
        m_err   = (bps != 512) || (nf == 0);
`ifdef BPB_SIGNATURE_CHECK_EN
        if (img[510] != 8'h55 || img[511] != 8'hAA) m_err = 1'b1;
`endif
        m_rsvd  = 16'(rsvd);
        m_nf    = 8'(nf);
        m_spc   = img[13];
        m_fsz   = fsz[31:0];
        m_rclus = rclus[31:0];
    endtask

    // Streams img; returns with done high (or after a timeout with lat = -1).
    task automatic run_sector(input logic [31:0] plba, input bit gapped, input bit mid_start,
                              output int lat, output bit busy_ok);
        busy_ok = 1'b1;
        @(posedge clk); #1;
        bif.start = 1'b1;
        bif.part_lba = plba;
        @(posedge clk); #1;
        bif.start = 1'b0;
        for (int i = 0; i < 512; i++) begin
            if (gapped) begin
                int n;
                n = $urandom_range(0, 2);
                for (int j = 0; j < n; j++) begin
                    bif.byte_valid = 1'b0;
                    @(posedge clk); #1;
                    if (!bif.busy) busy_ok = 1'b0;
                end
            end
            if (mid_start && i == 100) begin
                bif.start = 1'b1;
                bif.part_lba = ~plba;
            end
            bif.byte_valid = 1'b1;
            bif.byte_data = img[i];
            @(posedge clk); #1;
            bif.start = 1'b0;
            if (!bif.busy) busy_ok = 1'b0;
        end
        bif.byte_valid = 1'b0;
        lat = 1;
        while (!bif.done && lat < 40) begin
            if (!bif.busy) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        if (!bif.done) lat = -1;
    endtask

    // Compares the result while done is high, then steps one cycle past it.
    task automatic check_run(input string tag, input logic [31:0] e_root, input logic e_err,
                             input int lat, input bit busy_ok);
        chk({tag, ".latency"}, 64'(lat), 64'd10);
        chk({tag, ".busy_held"}, 64'(busy_ok), 64'd1);
        chk({tag, ".busy_at_done"}, 64'(bif.busy), 64'd0);
        chk({tag, ".root_dir_sector"}, 64'(bif.root_dir_sector), 64'(e_root));
        chk({tag, ".error"}, 64'(bif.error), 64'(e_err));
        chk({tag, ".reserved_sectors"}, 64'(bif.reserved_sectors), 64'(m_rsvd));
        chk({tag, ".num_fats"}, 64'(bif.num_fats), 64'(m_nf));
        chk({tag, ".sectors_per_cluster"}, 64'(bif.sectors_per_cluster), 64'(m_spc));
        chk({tag, ".fat_size"}, 64'(bif.fat_size), 64'(m_fsz));
        chk({tag, ".root_cluster"}, 64'(bif.root_cluster), 64'(m_rclus));
        @(posedge clk); #1;
        chk({tag, ".done_one_cycle"}, 64'(bif.done), 64'd0);
    endtask

    localparam logic SIG_ERR =
`ifdef BPB_SIGNATURE_CHECK_EN
        1'b1;
`else
        1'b0;
`endif

    vec_t tbl [7];
    int   lat;
    bit   bok;

    initial begin
        tbl[0] = '{32'd0,    32, 2, 32'h3C1, 512,  8, 32'd2, 8'hAA, 1'b0, 32'd1954,  1'b0};
        tbl[1] = '{32'd8192, 32, 2, 32'h3C1, 512,  8, 32'd2, 8'hAA, 1'b0, 32'd10146, 1'b0};
        tbl[2] = '{32'd8192, 32, 2, 32'h3C1, 512,  8, 32'd2, 8'hAA, 1'b1, 32'd10146, 1'b0};
        tbl[3] = '{32'd0,    32, 2, 32'h3C1, 4096, 8, 32'd2, 8'hAA, 1'b0, 32'd1954,  1'b1};
        tbl[4] = '{32'd0,    32, 0, 32'h3C1, 512,  8, 32'd2, 8'hAA, 1'b0, 32'd32,    1'b1};
        tbl[5] = '{32'd0,    32, 2, 32'h3C1, 512,  8, 32'd2, 8'hAA, 1'b1, 32'd1954,  1'b0};
        tbl[6] = '{32'd0,    32, 2, 32'h3C1, 512,  8, 32'd2, 8'hAB, 1'b0, 32'd1954,  SIG_ERR};

        bif.start = 1'b0;
        bif.part_lba = '0;
        bif.byte_valid = 1'b0;
        bif.byte_data = '0;
        sys_rst_n = 1'b0;
        #1;
        chk("reset.busy", 64'(bif.busy), 64'd0);
        chk("reset.done", 64'(bif.done), 64'd0);
        chk("reset.error", 64'(bif.error), 64'd0);
        chk("reset.root_dir_sector", 64'(bif.root_dir_sector), 64'd0);
        chk("reset.fat_size", 64'(bif.fat_size), 64'd0);
        repeat (3) @(posedge clk);
        #1 sys_rst_n = 1'b1;

        for (int k = 0; k < 7; k++) begin
            build_img(tbl[k].rsvd, tbl[k].nf, tbl[k].fsz, tbl[k].bps, tbl[k].spc,
                      tbl[k].rclus, 8'h55, tbl[k].s1);
            m_rsvd = 16'(tbl[k].rsvd); m_nf = 8'(tbl[k].nf); m_spc = 8'(tbl[k].spc);
            m_fsz = tbl[k].fsz; m_rclus = tbl[k].rclus;
            run_sector(tbl[k].plba, tbl[k].gapped, k == 1, lat, bok);
            check_run($sformatf("vec%0d", k), tbl[k].exp_root, tbl[k].exp_err, lat, bok);
        end

        // start coincident with done must not arm a parse.
        build_img(32, 2, 32'h3C1, 512, 8, 32'd2, 8'h55, 8'hAA);
        run_sector(32'd0, 1'b0, 1'b0, lat, bok);
        chk("start_at_done.seen_done", 64'(bif.done), 64'd1);
        bif.start = 1'b1;
        bif.part_lba = 32'd5;
        @(posedge clk); #1;
        bif.start = 1'b0;
        chk("start_at_done.busy", 64'(bif.busy), 64'd0);
        @(posedge clk); #1;
        chk("start_at_done.busy_later", 64'(bif.busy), 64'd0);

        // byte_valid in IDLE must not advance the counter.
        bif.byte_valid = 1'b1;
        bif.byte_data = 8'hFF;
        repeat (5) @(posedge clk);
        #1 bif.byte_valid = 1'b0;
        build_img(100, 3, 32'd1000, 512, 4, 32'd7, 8'h55, 8'hAA);
        ref_model(32'd64);
        run_sector(32'd64, 1'b0, 1'b0, lat, bok);
        check_run("idle_bytes", 32'd3164, 1'b0, lat, bok);

        // Reset in the middle of a sector.
        build_img(32, 2, 32'h3C1, 512, 8, 32'd2, 8'h55, 8'hAA);
        @(posedge clk); #1;
        bif.start = 1'b1;
        bif.part_lba = 32'd8192;
        @(posedge clk); #1;
        bif.start = 1'b0;
        for (int i = 0; i < 200; i++) begin
            bif.byte_valid = 1'b1;
            bif.byte_data = img[i];
            @(posedge clk); #1;
        end
        sys_rst_n = 1'b0;
        #1;
        chk("midreset.busy", 64'(bif.busy), 64'd0);
        chk("midreset.reserved_sectors", 64'(bif.reserved_sectors), 64'd0);
        chk("midreset.num_fats", 64'(bif.num_fats), 64'd0);
        chk("midreset.root_dir_sector", 64'(bif.root_dir_sector), 64'd0);
        begin
            bit saw_done;
            saw_done = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(posedge clk); #1;
                if (bif.done) saw_done = 1'b1;
            end
            chk("midreset.no_done", 64'(saw_done), 64'd0);
        end
        bif.byte_valid = 1'b0;
        sys_rst_n = 1'b1;
        ref_model(32'd8192);
        run_sector(32'd8192, 1'b0, 1'b0, lat, bok);
        check_run("after_reset", 32'd10146, 1'b0, lat, bok);

        // Randomized sectors against the reference model.
        for (int r = 0; r < 12; r++) begin
            int unsigned nf;
            logic [31:0] plba;
            nf = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 255);
            plba = $urandom;
            build_img($urandom_range(1, 65535), nf, $urandom,
                      ($urandom_range(0, 5) == 0) ? 4096 : 512,
                      $urandom_range(1, 128), $urandom, 8'h55,
                      ($urandom_range(0, 4) == 0) ? 8'hAB : 8'hAA);
            ref_model(plba);
            run_sector(plba, 1'($urandom_range(0, 1)), 1'b0, lat, bok);
            check_run($sformatf("rand%0d", r), m_root, m_err, lat, bok);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
